// File: rtl/hazard_ctrl.sv
// Hazard/stall controller for the 5-stage RV32 pipeline: stage enables, bubbles,
// EX operand forwarding, data-memory wait watchdog and saturating statistics.
module hazard_ctrl #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_aa,
  input  logic [4:0]       id_ba,
  input  logic             id_use_a,
  input  logic             id_use_b,
  input  logic [4:0]       ex_aa,
  input  logic [4:0]       ex_ba,
  input  logic [4:0]       ex_da,
  input  logic             ex_rw,
  input  logic             ex_mr,
  input  logic             ex_redirect,
  input  logic [4:0]       mem_da,
  input  logic             mem_rw,
  input  logic             mem_mr,
  input  logic [4:0]       wb_da,
  input  logic             wb_rw,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             idex_we,
  output logic             exmem_we,
  output logic             memwb_we,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             pc_sel,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned WaitW = $clog2(TIMEOUT + 1);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CntMax = '1;

  typedef enum logic [1:0] {StRun, StWait, StError} state_e;

  state_e           state_q;
  logic [WaitW-1:0] wait_cnt_q;
  logic             mem_stall;
  logic             freeze;
  logic             lu;
  logic             stall_inc;
  logic             flush_inc;

  assign mem_stall = mem_req & ~mem_ready;
  assign freeze    = mem_stall | (state_q == StError);
  assign lu        = ex_mr & ex_rw & (ex_da != 5'd0) &
                     ((id_use_a & (id_aa == ex_da)) | (id_use_b & (id_ba == ex_da)));
  assign stall_inc = freeze | (lu & ~ex_redirect);
  assign flush_inc = ex_redirect & ~freeze;

  // Loads are excluded from the MEM path: their data only exists from WB onwards.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src, input logic [4:0] m_da,
                                         input logic m_rw, input logic m_mr,
                                         input logic [4:0] w_da, input logic w_rw);
    if (src == 5'd0)                      return 2'b00;
    else if (m_rw && !m_mr && m_da == src) return 2'b01;
    else if (w_rw && w_da == src)          return 2'b10;
    else                                   return 2'b00;
  endfunction

  assign fwd_a = fwd_sel(ex_aa, mem_da, mem_rw, mem_mr, wb_da, wb_rw);
  assign fwd_b = fwd_sel(ex_ba, mem_da, mem_rw, mem_mr, wb_da, wb_rw);

  always_comb begin
    pc_we      = 1'b1;
    ifid_we    = 1'b1;
    idex_we    = 1'b1;
    exmem_we   = 1'b1;
    memwb_we   = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    pc_sel     = 1'b0;
    if (freeze) begin
      pc_we    = 1'b0;
      ifid_we  = 1'b0;
      idex_we  = 1'b0;
      exmem_we = 1'b0;
      memwb_we = 1'b0;
    end else if (ex_redirect) begin
      // Wrong-path ID instruction is squashed, so any load-use on it is moot.
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      pc_sel     = 1'b1;
    end else if (lu) begin
      pc_we      = 1'b0;
      ifid_we    = 1'b0;
      idex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StRun;
      wait_cnt_q <= '0;
      mem_err    <= 1'b0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (mem_stall) begin
            state_q    <= StWait;
            wait_cnt_q <= WaitW'(1);
          end
        end
        StWait: begin
          if (!mem_stall) begin
            state_q    <= StRun;
            wait_cnt_q <= '0;
          end else if (wait_cnt_q == WaitLast) begin
            state_q <= StError;
            mem_err <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + WaitW'(1);
          end
        end
        StError: mem_err <= 1'b1;
        default: state_q <= StRun;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_inc && stall_cnt != CntMax) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_inc && flush_cnt != CntMax) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule
